regfile_wb_sched: RTL and testbench

REGFILE_WB_SCHED -- requirements
Module: regfile_wb_sched

---
 rtl/regfile_wb_sched_if.sv | 46 ++++
 rtl/regfile_wb_sched.sv | 89 ++++++++
 tb/tb_regfile_wb_sched.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_sched_if.sv
// rtl/regfile_wb_sched_if.sv - issue, writeback and register-file write bundle for the writeback scheduler
interface regfile_wb_sched_if #(
  parameter int AW = 4,
  parameter int DW = 32
);
  localparam int NR = 1 << AW;

  logic          iss_valid;
  logic          iss_ready;
  logic [AW-1:0] iss_rs1;
  logic [AW-1:0] iss_rs2;
  logic          iss_wr;
  logic [AW-1:0] iss_rd;

  logic          wb0_valid;
  logic          wb0_ready;
  logic [AW-1:0] wb0_addr;
  logic [DW-1:0] wb0_data;

  logic          wb1_valid;
  logic          wb1_ready;
  logic [AW-1:0] wb1_addr;
  logic [DW-1:0] wb1_data;

  logic          rd_write;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_wdata;
  logic [NR-1:0] busy;
  logic          err_spurious;

  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_wr, iss_rd,
    output wb0_valid, wb0_addr, wb0_data,
    output wb1_valid, wb1_addr, wb1_data,
    input  iss_ready, wb0_ready, wb1_ready,
    input  rd_write, rd_addr, rd_wdata, busy, err_spurious
  );

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_wr, iss_rd,
    input  wb0_valid, wb0_addr, wb0_data,
    input  wb1_valid, wb1_addr, wb1_data,
    output iss_ready, wb0_ready, wb1_ready,
    output rd_write, rd_addr, rd_wdata, busy, err_spurious
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// rtl/regfile_wb_sched.sv - register scoreboard with round-robin two-port writeback arbitration
module regfile_wb_sched #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input logic               clk,
  input logic               rst,
  regfile_wb_sched_if.slave bus
);
  localparam int NR = 1 << AW;

  logic [NR-1:0] r_busy;
  logic          r_prio;
  logic          r_rd_write;
  logic [AW-1:0] r_rd_addr;
  logic [DW-1:0] r_rd_wdata;
  logic          r_err;

  logic          w_hit;
  logic          w_iss_ready;
  logic          w_iss_fire;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_acc;
  logic [AW-1:0] w_wb_addr;
  logic [DW-1:0] w_wb_data;
  logic          w_wb_nz;
  logic [NR-1:0] w_set;
  logic [NR-1:0] w_clr;
  logic [NR-1:0] w_busy_nxt;

  // A source that is being written this very cycle is still stale in the register file.
  assign w_hit = r_rd_write && (r_rd_addr != '0) &&
                 ((r_rd_addr == bus.iss_rs1) || (r_rd_addr == bus.iss_rs2));

  assign w_iss_ready = !(r_busy[bus.iss_rs1] || r_busy[bus.iss_rs2] ||
                         (bus.iss_wr && r_busy[bus.iss_rd]) || w_hit);
  assign w_iss_fire  = bus.iss_valid && w_iss_ready && bus.iss_wr && (bus.iss_rd != '0);

  // Sole requester always wins; on contention the pointer picks.
  assign w_gnt0 = bus.wb0_valid && (!bus.wb1_valid || !r_prio);
  assign w_gnt1 = bus.wb1_valid && (!bus.wb0_valid ||  r_prio);
  assign w_acc  = w_gnt0 || w_gnt1;

  assign w_wb_addr = w_gnt1 ? bus.wb1_addr : bus.wb0_addr;
  assign w_wb_data = w_gnt1 ? bus.wb1_data : bus.wb0_data;
  assign w_wb_nz   = w_wb_addr != '0;

  // Scoreboard update: clear on accepted writeback, set on issue; set is applied last so it wins.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_acc)      w_clr[w_wb_addr]  = 1'b1;
    if (w_iss_fire) w_set[bus.iss_rd] = 1'b1;
    w_busy_nxt    = (r_busy & ~w_clr) | w_set;
    w_busy_nxt[0] = 1'b0;
  end

  // State registers: scoreboard, arbitration pointer and the registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= '0;
      r_prio     <= 1'b0;
      r_rd_write <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_wdata <= '0;
      r_err      <= 1'b0;
    end else begin
      r_busy     <= w_busy_nxt;
      if (w_gnt0)      r_prio <= 1'b1;
      else if (w_gnt1) r_prio <= 1'b0;
      r_rd_write <= w_acc && w_wb_nz;
      if (w_acc) begin
        r_rd_addr  <= w_wb_addr;
        r_rd_wdata <= w_wb_data;
      end
      r_err      <= w_acc && w_wb_nz && !r_busy[w_wb_addr];
    end
  end

  assign bus.iss_ready    = w_iss_ready;
  assign bus.wb0_ready    = w_gnt0;
  assign bus.wb1_ready    = w_gnt1;
  assign bus.rd_write     = r_rd_write;
  assign bus.rd_addr      = r_rd_addr;
  assign bus.rd_wdata     = r_rd_wdata;
  assign bus.busy         = r_busy;
  assign bus.err_spurious = r_err;
endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb/tb_regfile_wb_sched.sv - directed self-checking bench for regfile_wb_sched
module tb_regfile_wb_sched;
  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  regfile_wb_sched_if #(.AW(4), .DW(32)) bus ();

  regfile_wb_sched #(.AW(4), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] d0;
  logic [31:0] d1;
  int          g;

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    n_total = 0;
    n_bad = 0;
    bus.iss_valid = 0; bus.iss_rs1 = 0; bus.iss_rs2 = 0; bus.iss_wr = 0; bus.iss_rd = 0;
    bus.wb0_valid = 0; bus.wb0_addr = 0; bus.wb0_data = 0;
    bus.wb1_valid = 0; bus.wb1_addr = 0; bus.wb1_data = 0;

    tick();
    chk("rst_iss_ready", bus.iss_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rd_write", bus.rd_write, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_rd_wdata", bus.rd_wdata, 0);
    chk("rst_err", bus.err_spurious, 0);
    tick();
    rst = 1'b0;

    // RAW hazard on r5 until the writeback commits
    bus.iss_valid = 1; bus.iss_wr = 1; bus.iss_rd = 5;
    #1 chk("raw_issue_ready", bus.iss_ready, 1);
    tick();
    chk("raw_busy5", bus.busy, 16'h0020);
    bus.iss_wr = 0; bus.iss_rd = 0; bus.iss_rs1 = 5;
    #1 chk("raw_blocked0", bus.iss_ready, 0);
    tick();
    chk("raw_blocked1", bus.iss_ready, 0);
    bus.wb0_valid = 1; bus.wb0_addr = 5; bus.wb0_data = 32'h55;
    #1;
    chk("raw_wb0_ready", bus.wb0_ready, 1);
    chk("raw_wb1_ready", bus.wb1_ready, 0);
    chk("raw_blocked2", bus.iss_ready, 0);
    tick();
    chk("raw_rd_write", bus.rd_write, 1);
    chk("raw_rd_addr", bus.rd_addr, 5);
    chk("raw_rd_wdata", bus.rd_wdata, 32'h55);
    chk("raw_busy_clr", bus.busy, 0);
    chk("raw_no_err", bus.err_spurious, 0);
    chk("raw_hit_block", bus.iss_ready, 0);
    bus.wb0_valid = 0;
    tick();
    chk("raw_rd_write_low", bus.rd_write, 0);
    chk("raw_ready_again", bus.iss_ready, 1);
    bus.iss_valid = 0; bus.iss_rs1 = 0;

    // Register 0 is never tracked or written
    bus.iss_valid = 1; bus.iss_wr = 1; bus.iss_rd = 0;
    tick();
    chk("r0_busy", bus.busy, 0);
    bus.iss_valid = 0; bus.iss_wr = 0;
    bus.wb1_valid = 1; bus.wb1_addr = 0; bus.wb1_data = 32'hDEADBEEF;
    #1;
    chk("r0_wb1_ready", bus.wb1_ready, 1);
    chk("r0_wb0_ready", bus.wb0_ready, 0);
    tick();
    chk("r0_rd_write", bus.rd_write, 0);
    chk("r0_rd_wdata", bus.rd_wdata, 32'hDEADBEEF);
    chk("r0_err", bus.err_spurious, 0);
    chk("r0_busy2", bus.busy, 0);
    bus.wb1_valid = 0;

    // Spurious writeback to a non-busy register
    bus.wb0_valid = 1; bus.wb0_addr = 7; bus.wb0_data = 32'h77;
    tick();
    chk("sp_rd_write", bus.rd_write, 1);
    chk("sp_rd_addr", bus.rd_addr, 7);
    chk("sp_err", bus.err_spurious, 1);
    bus.wb0_valid = 0;
    tick();
    chk("sp_err_pulse", bus.err_spurious, 0);
    chk("sp_rd_write_low", bus.rd_write, 0);
    chk("sp_rd_addr_hold", bus.rd_addr, 7);
    chk("sp_rd_wdata_hold", bus.rd_wdata, 32'h77);

    // Set and clear of r9 on the same edge: set wins
    bus.iss_valid = 1; bus.iss_wr = 1; bus.iss_rd = 9;
    bus.wb0_valid = 1; bus.wb0_addr = 9; bus.wb0_data = 32'h99;
    #1 chk("sc_ready", bus.iss_ready, 1);
    tick();
    chk("sc_busy9", bus.busy, 16'h0200);
    chk("sc_err", bus.err_spurious, 1);
    chk("sc_rd_write", bus.rd_write, 1);
    bus.iss_valid = 0; bus.iss_wr = 0; bus.iss_rd = 0;
    bus.wb0_data = 32'h9A;
    tick();
    chk("sc_busy_clr", bus.busy, 0);
    chk("sc_err_low", bus.err_spurious, 0);
    chk("sc_rd_wdata", bus.rd_wdata, 32'h9A);
    bus.wb0_valid = 0;

    // Contention after two wb0 grants: pointer favours wb1
    bus.wb0_valid = 1; bus.wb1_valid = 1;
    #1;
    chk("ct_wb0_ready", bus.wb0_ready, 0);
    chk("ct_wb1_ready", bus.wb1_ready, 1);
    bus.wb0_valid = 0; bus.wb1_valid = 0;

    // Reset with r3 busy and wb1 pending
    bus.iss_valid = 1; bus.iss_wr = 1; bus.iss_rd = 3;
    tick();
    chk("mr_busy3", bus.busy, 16'h0008);
    bus.iss_valid = 0; bus.iss_wr = 0; bus.iss_rd = 0;
    bus.wb1_valid = 1; bus.wb1_addr = 3; bus.wb1_data = 32'h33;
    rst = 1'b1;
    tick();
    chk("mr_busy", bus.busy, 0);
    chk("mr_rd_write", bus.rd_write, 0);
    chk("mr_rd_addr", bus.rd_addr, 0);
    chk("mr_rd_wdata", bus.rd_wdata, 0);
    chk("mr_err", bus.err_spurious, 0);
    rst = 1'b0; bus.wb1_valid = 0;
    tick();
    chk("mr_no_write", bus.rd_write, 0);
    chk("mr_busy_after", bus.busy, 0);
    bus.wb0_valid = 1; bus.wb1_valid = 1;
    #1;
    chk("mr_prio_wb0", bus.wb0_ready, 1);
    chk("mr_prio_wb1", bus.wb1_ready, 0);
    bus.wb0_valid = 0; bus.wb1_valid = 0;

    // Round-robin after reset: 0,1,0,1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    d0 = 32'hA0; d1 = 32'hB0;
    bus.wb0_valid = 1; bus.wb0_addr = 1; bus.wb0_data = d0;
    bus.wb1_valid = 1; bus.wb1_addr = 2; bus.wb1_data = d1;
    for (int k = 0; k < 4; k++) begin
      g = k % 2;
      #1;
      chk($sformatf("rr%0d_wb0_ready", k), bus.wb0_ready, (g == 0));
      chk($sformatf("rr%0d_wb1_ready", k), bus.wb1_ready, (g == 1));
      tick();
      chk($sformatf("rr%0d_rd_write", k), bus.rd_write, 1);
      chk($sformatf("rr%0d_rd_addr", k), bus.rd_addr, (g == 0) ? 1 : 2);
      chk($sformatf("rr%0d_rd_wdata", k), bus.rd_wdata, (g == 0) ? d0 : d1);
      if (g == 0) begin
        d0 = d0 + 1;
        bus.wb0_data = d0;
      end else begin
        d1 = d1 + 1;
        bus.wb1_data = d1;
      end
    end
    bus.wb0_valid = 0; bus.wb1_valid = 0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
